vx_mem_perf_monitor: RTL and testbench
======================================

Name: vx_mem_perf_monitor

Overview:
Multi-channel successor to the single-port memory perf counters kept at the GPU top. It passively taps NUM_PORTS memory channels (request and response handshakes) and keeps per-port counters: reads, writes, latency (pending-read integral), peak outstanding reads and an underflow flag. It adds clear and atomic snapshot controls and a registered readout mux. It sits beside the L3/memory boundary and never back-pressures the bus.

Parameters:
NUM_PORTS, 1, number of monitored memory channels (1..16)
CTR_BITS, 44, width of reads/writes/latency counters (matches PERF_CTR_BITS)
PEND_BITS, 16, width of per-port pending and peak counters
SATURATE, 0, 1 = counters saturate at all-ones; 0 = modular wrap

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
mem_req_valid  in  NUM_PORTS  per-port request valid
mem_req_ready  in  NUM_PORTS  per-port request ready
mem_req_rw  in  NUM_PORTS  1 = write, 0 = read
mem_rsp_valid  in  NUM_PORTS  per-port read-response valid
mem_rsp_ready  in  NUM_PORTS  per-port read-response ready
ctr_clear  in  1  zero live reads/writes/latency/peak/underflow
ctr_snap  in  1  copy live counters into shadow set
rd_port  in  clog2(NUM_PORTS) or 1  port index for readout
rd_sel  in  3  0=reads 1=writes 2=latency 3=pending 4=peak 5=underflow; 6,7 read as 0
rd_data  out  CTR_BITS  selected shadow value, zero-extended
snap_done  out  1  one-cycle pulse the cycle after a snapshot is taken

Behaviour:
- Async reset: all live, shadow and pending registers, rd_data and snap_done = 0.
- req_fire[i] = valid&ready; rsp_fire[i] = valid&ready. Inputs are sampled only; the block has no outputs toward the bus.
- reads[i] += req_fire & ~rw; writes[i] += req_fire & rw; each is updated every cycle.
- pending[i]: +1 on a read fire, -1 on a response fire; a simultaneous read fire and response fire leaves it unchanged.
- Response fire with pending = 0: pending stays 0 and the sticky underflow[i] is set.
- Read fire with pending = all-ones: pending holds.
- latency[i] += pending[i] (pre-update value) every cycle.
- peak[i] <= max(peak[i], next pending[i]).
- SATURATE=1: reads/writes/latency clamp at 2^CTR_BITS-1. SATURATE=0: they wrap modulo 2^CTR_BITS.
- ctr_clear, next edge: reads, writes, latency and underflow go to 0 and peak goes to the current pending. Pending itself is never cleared, so in-flight tracking stays correct. Events in the clear cycle are discarded.
- ctr_snap: the shadow set takes the live values as they stand before this edge's update. snap_done pulses the next cycle.
- ctr_snap and ctr_clear together: the snapshot captures pre-clear values and the live set is cleared.
- Readout: rd_data is registered, 1-cycle latency from rd_port/rd_sel, and always sources the shadow set. Pending and peak are zero-extended. An out-of-range rd_port returns 0.
- No FSM beyond the snap_done pulse. The control is purely per-cycle; a reset mid-operation discards everything.

Decomposition:
- Package vx_gpu_pkg gains:
  - typedef mem_perf_sel_t (3-bit enum, values as for rd_sel);
  - localparam MEM_PERF_SEL_COUNT = 6;
  - struct mem_port_perf_t {reads, writes, latency, pending, peak, underflow}.
- Sub-module vx_mem_port_perf_ctr: one port's live counters with its clear/saturate logic, instantiated NUM_PORTS times.
- The top module holds the shadow array, the snapshot/clear control and the readout mux.

Test Plan:
- NUM_PORTS=2, port 0 issues 5 read fires and 3 write fires, no responses; snap, then read rd_sel 0/1/3 -> reads=5, writes=3, pending=5; port 1 reads all 0.
- Port 0: one read at cycle 0, response at cycle 10; snap at cycle 20 -> latency=10, pending=0, peak=1.
- Simultaneous read fire and response fire with pending=2 -> pending stays 2; peak unchanged at 2.
- Response fire with pending=0 -> pending=0, underflow=1. Then ctr_clear -> underflow=0 and reads=0, with pending preserved.
- CTR_BITS=4, SATURATE=0: 17 read fires -> reads=1. SATURATE=1: same stimulus -> reads=15.
- ctr_snap and ctr_clear in the same cycle with reads=7 -> shadow reads=7, snap_done pulses next cycle; a second snap 1 cycle later -> reads=0. Assert reset mid-stream -> rd_data=0 next readout.

Source files
------------

// File: rtl/vx_gpu_pkg.sv
// Shared GPU types for the memory performance monitor: readout selector,
// counter limits and the per-port counter record kept in the snapshot set.
package vx_gpu_pkg;

  localparam int MEM_PERF_SEL_COUNT = 6;
  localparam int MEM_PERF_CTR_MAX   = 64;
  localparam int MEM_PERF_PEND_MAX  = 32;

  typedef enum logic [2:0] {
    MEM_PERF_SEL_READS     = 3'd0,
    MEM_PERF_SEL_WRITES    = 3'd1,
    MEM_PERF_SEL_LATENCY   = 3'd2,
    MEM_PERF_SEL_PENDING   = 3'd3,
    MEM_PERF_SEL_PEAK      = 3'd4,
    MEM_PERF_SEL_UNDERFLOW = 3'd5
  } mem_perf_sel_t;

  // Fields are sized for the widest legal configuration; narrower
  // instances zero-extend into them.
  typedef struct packed {
    logic [MEM_PERF_CTR_MAX-1:0]  reads;
    logic [MEM_PERF_CTR_MAX-1:0]  writes;
    logic [MEM_PERF_CTR_MAX-1:0]  latency;
    logic [MEM_PERF_PEND_MAX-1:0] pending;
    logic [MEM_PERF_PEND_MAX-1:0] peak;
    logic                         underflow;
  } mem_port_perf_t;

endpackage

// File: rtl/vx_mem_port_perf_ctr.sv
// Live counters for one monitored memory channel: read/write counts,
// pending-read integral, outstanding/peak tracking and sticky underflow.
module vx_mem_port_perf_ctr #(
  parameter int CTR_BITS  = 44,
  parameter int PEND_BITS = 16,
  parameter int SATURATE  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_fire_i,
  input  logic                 req_rw_i,
  input  logic                 rsp_fire_i,
  input  logic                 clear_i,
  output logic [CTR_BITS-1:0]  reads_o,
  output logic [CTR_BITS-1:0]  writes_o,
  output logic [CTR_BITS-1:0]  latency_o,
  output logic [PEND_BITS-1:0] pending_o,
  output logic [PEND_BITS-1:0] peak_o,
  output logic                 underflow_o
);

  localparam int SUM_W = ((CTR_BITS > PEND_BITS) ? CTR_BITS : PEND_BITS) + 1;
  localparam logic [CTR_BITS-1:0]  CTR_ALL_ONES  = '1;
  localparam logic [PEND_BITS-1:0] PEND_ALL_ONES = '1;

  logic [CTR_BITS-1:0]  reads_q, reads_d;
  logic [CTR_BITS-1:0]  writes_q, writes_d;
  logic [CTR_BITS-1:0]  latency_q, latency_d;
  logic [PEND_BITS-1:0] pending_q, pending_d;
  logic [PEND_BITS-1:0] peak_q, peak_d;
  logic                 underflow_q, underflow_d;
  logic                 rd_fire, wr_fire;

  // The extra sum bit exposes the carry, so saturation is a simple compare.
  function automatic logic [CTR_BITS-1:0] ctr_add(input logic [CTR_BITS-1:0] base,
                                                  input logic [SUM_W-1:0]    inc);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(base) + inc;
    if ((SATURATE != 0) && (sum > SUM_W'(CTR_ALL_ONES)))
      return CTR_ALL_ONES;
    return sum[CTR_BITS-1:0];
  endfunction

  always_comb begin
    rd_fire     = req_fire_i & ~req_rw_i;
    wr_fire     = req_fire_i & req_rw_i;
    pending_d   = pending_q;
    underflow_d = underflow_q;
    if (rd_fire && !rsp_fire_i) begin
      if (pending_q != PEND_ALL_ONES)
        pending_d = pending_q + PEND_BITS'(1);
    end else if (rsp_fire_i && !rd_fire) begin
      if (pending_q == '0)
        underflow_d = 1'b1;
      else
        pending_d = pending_q - PEND_BITS'(1);
    end
    peak_d    = (pending_d > peak_q) ? pending_d : peak_q;
    reads_d   = ctr_add(reads_q, SUM_W'(rd_fire));
    writes_d  = ctr_add(writes_q, SUM_W'(wr_fire));
    latency_d = ctr_add(latency_q, SUM_W'(pending_q));
    // Pending keeps tracking through a clear; peak restarts from it so that
    // peak never drops below the outstanding count.
    if (clear_i) begin
      reads_d     = '0;
      writes_d    = '0;
      latency_d   = '0;
      underflow_d = 1'b0;
      peak_d      = pending_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reads_q     <= '0;
      writes_q    <= '0;
      latency_q   <= '0;
      pending_q   <= '0;
      peak_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      reads_q     <= reads_d;
      writes_q    <= writes_d;
      latency_q   <= latency_d;
      pending_q   <= pending_d;
      peak_q      <= peak_d;
      underflow_q <= underflow_d;
    end
  end

  assign reads_o     = reads_q;
  assign writes_o    = writes_q;
  assign latency_o   = latency_q;
  assign pending_o   = pending_q;
  assign peak_o      = peak_q;
  assign underflow_o = underflow_q;

endmodule

// File: rtl/vx_mem_perf_monitor.sv
// Passive multi-channel memory performance monitor: per-port live counters,
// an atomic shadow snapshot and a registered readout mux over the shadow set.
module vx_mem_perf_monitor
  import vx_gpu_pkg::*;
#(
  parameter int NUM_PORTS = 1,
  parameter int CTR_BITS  = 44,
  parameter int PEND_BITS = 16,
  parameter int SATURATE  = 0,
  localparam int PORT_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] mem_req_valid,
  input  logic [NUM_PORTS-1:0] mem_req_ready,
  input  logic [NUM_PORTS-1:0] mem_req_rw,
  input  logic [NUM_PORTS-1:0] mem_rsp_valid,
  input  logic [NUM_PORTS-1:0] mem_rsp_ready,
  input  logic                 ctr_clear,
  input  logic                 ctr_snap,
  input  logic [PORT_W-1:0]    rd_port,
  input  logic [2:0]           rd_sel,
  output logic [CTR_BITS-1:0]  rd_data,
  output logic                 snap_done
);

  mem_port_perf_t      live_perf [NUM_PORTS];
  mem_port_perf_t      shadow_q  [NUM_PORTS];
  mem_port_perf_t      sel_perf;
  logic [CTR_BITS-1:0] rd_data_q, rd_data_d;
  logic                snap_done_q;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [CTR_BITS-1:0]  reads, writes, latency;
    logic [PEND_BITS-1:0] pending, peak;
    logic                 underflow;

    vx_mem_port_perf_ctr #(
      .CTR_BITS  (CTR_BITS),
      .PEND_BITS (PEND_BITS),
      .SATURATE  (SATURATE)
    ) u_ctr (
      .clk         (clk),
      .reset       (reset),
      .req_fire_i  (mem_req_valid[p] & mem_req_ready[p]),
      .req_rw_i    (mem_req_rw[p]),
      .rsp_fire_i  (mem_rsp_valid[p] & mem_rsp_ready[p]),
      .clear_i     (ctr_clear),
      .reads_o     (reads),
      .writes_o    (writes),
      .latency_o   (latency),
      .pending_o   (pending),
      .peak_o      (peak),
      .underflow_o (underflow)
    );

    assign live_perf[p] = '{reads:     MEM_PERF_CTR_MAX'(reads),
                            writes:    MEM_PERF_CTR_MAX'(writes),
                            latency:   MEM_PERF_CTR_MAX'(latency),
                            pending:   MEM_PERF_PEND_MAX'(pending),
                            peak:      MEM_PERF_PEND_MAX'(peak),
                            underflow: underflow};
  end

  // Live registers still hold their pre-edge values here, so a snapshot
  // taken together with a clear captures the pre-clear counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++)
        shadow_q[i] <= '0;
      snap_done_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      if (ctr_snap) begin
        for (int i = 0; i < NUM_PORTS; i++)
          shadow_q[i] <= live_perf[i];
      end
      snap_done_q <= ctr_snap;
      rd_data_q   <= rd_data_d;
    end
  end

  always_comb begin
    sel_perf = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (rd_port == PORT_W'(i))
        sel_perf = shadow_q[i];
    end
    rd_data_d = '0;
    if (int'(rd_sel) < MEM_PERF_SEL_COUNT) begin
      case (mem_perf_sel_t'(rd_sel))
        MEM_PERF_SEL_READS:     rd_data_d = CTR_BITS'(sel_perf.reads);
        MEM_PERF_SEL_WRITES:    rd_data_d = CTR_BITS'(sel_perf.writes);
        MEM_PERF_SEL_LATENCY:   rd_data_d = CTR_BITS'(sel_perf.latency);
        MEM_PERF_SEL_PENDING:   rd_data_d = CTR_BITS'(sel_perf.pending);
        MEM_PERF_SEL_PEAK:      rd_data_d = CTR_BITS'(sel_perf.peak);
        MEM_PERF_SEL_UNDERFLOW: rd_data_d = CTR_BITS'(sel_perf.underflow);
        default:                rd_data_d = '0;
      endcase
    end
  end

  assign rd_data   = rd_data_q;
  assign snap_done = snap_done_q;

endmodule

// File: tb/tb_vx_mem_perf_monitor.sv
// Directed bench for vx_mem_perf_monitor: a 2-port 44-bit instance plus
// 4-bit wrapping and saturating single-port instances.
module tb_vx_mem_perf_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req_valid = '0, req_ready = 2'b11, req_rw = '0;
  logic [1:0] rsp_valid = '0, rsp_ready = 2'b11;
  logic       ctr_clear = 1'b0, ctr_snap = 1'b0;
  logic       rd_port = 1'b0;
  logic [2:0] rd_sel = '0;
  logic [43:0] rd_data;
  logic       snap_done;

  logic       sm_req_valid = 1'b0, sm_snap = 1'b0;
  logic [2:0] sm_rd_sel = '0;
  logic [3:0] wrap_rd_data, sat_rd_data;
  logic       wrap_snap_done, sat_snap_done;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    string       name;
    logic        port;
    logic [2:0]  sel;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[14];

  always #5 clk = ~clk;

  vx_mem_perf_monitor #(.NUM_PORTS(2), .CTR_BITS(44), .PEND_BITS(16), .SATURATE(0)) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(req_valid), .mem_req_ready(req_ready), .mem_req_rw(req_rw),
    .mem_rsp_valid(rsp_valid), .mem_rsp_ready(rsp_ready),
    .ctr_clear(ctr_clear), .ctr_snap(ctr_snap),
    .rd_port(rd_port), .rd_sel(rd_sel), .rd_data(rd_data), .snap_done(snap_done)
  );

  vx_mem_perf_monitor #(.NUM_PORTS(1), .CTR_BITS(4), .PEND_BITS(16), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset),
    .mem_req_valid(sm_req_valid), .mem_req_ready(1'b1), .mem_req_rw(1'b0),
    .mem_rsp_valid(1'b0), .mem_rsp_ready(1'b1),
    .ctr_clear(1'b0), .ctr_snap(sm_snap),
    .rd_port(1'b0), .rd_sel(sm_rd_sel), .rd_data(wrap_rd_data), .snap_done(wrap_snap_done)
  );

  vx_mem_perf_monitor #(.NUM_PORTS(1), .CTR_BITS(4), .PEND_BITS(16), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset),
    .mem_req_valid(sm_req_valid), .mem_req_ready(1'b1), .mem_req_rw(1'b0),
    .mem_rsp_valid(1'b0), .mem_rsp_ready(1'b1),
    .ctr_clear(1'b0), .ctr_snap(sm_snap),
    .rd_port(1'b0), .rd_sel(sm_rd_sel), .rd_data(sat_rd_data), .snap_done(sat_snap_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock with the given port request/response pattern, then idle.
  task automatic applyStimulus(input logic [1:0] rv, input logic [1:0] rw, input logic [1:0] sv);
    req_valid = rv;
    req_rw    = rw;
    rsp_valid = sv;
    step();
    req_valid = '0;
    req_rw    = '0;
    rsp_valid = '0;
  endtask

  task automatic snapStep();
    ctr_snap = 1'b1;
    step();
    ctr_snap = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic port, input logic [2:0] sel,
                           input logic [63:0] exp);
    rd_port = port;
    rd_sel  = sel;
    step();
    checkOutput(name, 64'(rd_data), exp);
  endtask

  task automatic doReset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    vecs[0]  = '{"p0_reads",     1'b0, 3'd0, 64'd5};
    vecs[1]  = '{"p0_writes",    1'b0, 3'd1, 64'd3};
    vecs[2]  = '{"p0_latency",   1'b0, 3'd2, 64'd25};
    vecs[3]  = '{"p0_pending",   1'b0, 3'd3, 64'd5};
    vecs[4]  = '{"p0_peak",      1'b0, 3'd4, 64'd5};
    vecs[5]  = '{"p0_underflow", 1'b0, 3'd5, 64'd0};
    vecs[6]  = '{"p0_sel6",      1'b0, 3'd6, 64'd0};
    vecs[7]  = '{"p0_sel7",      1'b0, 3'd7, 64'd0};
    vecs[8]  = '{"p1_reads",     1'b1, 3'd0, 64'd0};
    vecs[9]  = '{"p1_writes",    1'b1, 3'd1, 64'd0};
    vecs[10] = '{"p1_latency",   1'b1, 3'd2, 64'd0};
    vecs[11] = '{"p1_pending",   1'b1, 3'd3, 64'd0};
    vecs[12] = '{"p1_peak",      1'b1, 3'd4, 64'd0};
    vecs[13] = '{"p1_underflow", 1'b1, 3'd5, 64'd0};

    step();
    checkOutput("reset_rd_data", 64'(rd_data), 64'd0);
    checkOutput("reset_snap_done", 64'(snap_done), 64'd0);
    doReset();

    // Five port-0 reads (after one valid-without-ready cycle), three writes.
    req_ready = 2'b10;
    applyStimulus(2'b01, 2'b00, 2'b00);
    req_ready = 2'b11;
    for (int i = 0; i < 5; i++) applyStimulus(2'b01, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) applyStimulus(2'b01, 2'b01, 2'b00);
    snapStep();
    checkOutput("snap_done_pulse", 64'(snap_done), 64'd1);
    for (int i = 0; i < 14; i++) readCheck(vecs[i].name, vecs[i].port, vecs[i].sel, vecs[i].exp);
    checkOutput("snap_done_low", 64'(snap_done), 64'd0);

    // Read at one edge, response ten edges later.
    doReset();
    applyStimulus(2'b01, 2'b00, 2'b00);
    for (int i = 0; i < 9; i++) step();
    applyStimulus(2'b00, 2'b00, 2'b01);
    for (int i = 0; i < 8; i++) step();
    snapStep();
    readCheck("lat_latency", 1'b0, 3'd2, 64'd10);
    readCheck("lat_pending", 1'b0, 3'd3, 64'd0);
    readCheck("lat_peak",    1'b0, 3'd4, 64'd1);

    // Simultaneous read and response fire with two outstanding.
    doReset();
    applyStimulus(2'b01, 2'b00, 2'b00);
    applyStimulus(2'b01, 2'b00, 2'b00);
    applyStimulus(2'b01, 2'b00, 2'b01);
    snapStep();
    readCheck("simul_pending", 1'b0, 3'd3, 64'd2);
    readCheck("simul_peak",    1'b0, 3'd4, 64'd2);
    readCheck("simul_reads",   1'b0, 3'd0, 64'd3);

    // Underflow, then clear keeps pending.
    doReset();
    applyStimulus(2'b00, 2'b00, 2'b01);
    applyStimulus(2'b01, 2'b00, 2'b00);
    snapStep();
    readCheck("uf_set",     1'b0, 3'd5, 64'd1);
    readCheck("uf_pending", 1'b0, 3'd3, 64'd1);
    readCheck("uf_reads",   1'b0, 3'd0, 64'd1);
    ctr_clear = 1'b1;
    step();
    ctr_clear = 1'b0;
    snapStep();
    readCheck("clr_underflow", 1'b0, 3'd5, 64'd0);
    readCheck("clr_reads",     1'b0, 3'd0, 64'd0);
    readCheck("clr_pending",   1'b0, 3'd3, 64'd1);
    readCheck("clr_peak",      1'b0, 3'd4, 64'd1);
    readCheck("clr_latency",   1'b0, 3'd2, 64'd0);

    // 4-bit counters: 17 reads, wrap vs saturate.
    doReset();
    sm_req_valid = 1'b1;
    for (int i = 0; i < 17; i++) step();
    sm_req_valid = 1'b0;
    sm_snap = 1'b1;
    step();
    sm_snap = 1'b0;
    sm_rd_sel = 3'd0;
    step();
    checkOutput("wrap_reads", 64'(wrap_rd_data), 64'd1);
    checkOutput("sat_reads",  64'(sat_rd_data),  64'd15);
    sm_rd_sel = 3'd2;
    step();
    checkOutput("wrap_latency", 64'(wrap_rd_data), 64'd8);
    checkOutput("sat_latency",  64'(sat_rd_data),  64'd15);

    // Snap and clear together, then a second snap one cycle later.
    doReset();
    for (int i = 0; i < 7; i++) applyStimulus(2'b01, 2'b00, 2'b00);
    ctr_clear = 1'b1;
    ctr_snap  = 1'b1;
    step();
    ctr_clear = 1'b0;
    checkOutput("snapclr_done", 64'(snap_done), 64'd1);
    rd_port = 1'b0;
    rd_sel  = 3'd0;
    step();
    ctr_snap = 1'b0;
    checkOutput("snapclr_reads", 64'(rd_data), 64'd7);
    checkOutput("snap2_done", 64'(snap_done), 64'd1);
    step();
    checkOutput("snap2_reads", 64'(rd_data), 64'd0);
    readCheck("snap2_pending", 1'b0, 3'd3, 64'd7);

    // Reset mid-stream discards everything.
    for (int i = 0; i < 3; i++) applyStimulus(2'b01, 2'b00, 2'b00);
    snapStep();
    readCheck("pre_reset_reads", 1'b0, 3'd0, 64'd3);
    #2;
    reset = 1'b1;
    #2;
    checkOutput("async_reset_rd_data", 64'(rd_data), 64'd0);
    step();
    reset = 1'b0;
    readCheck("post_reset_shadow", 1'b0, 3'd0, 64'd0);
    snapStep();
    readCheck("post_reset_live", 1'b0, 3'd3, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
